// File: rtl/pkt_ser_pkg.sv
// Shared symbol types, K-code constants and FSM state encoding for pkt_serializer.
// Build option: PKT_SERIALIZER_EOP_EN adds the ST_EOP state.
package pkt_ser_pkg;

  localparam int unsigned SYM_W = 9;

  // Symbol = {k, byte}; k marks a control code.
  typedef logic [SYM_W-1:0] sym_t;

  localparam sym_t COMMA = {1'b1, 8'h3C};
  localparam sym_t EOP   = {1'b1, 8'hFD};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SOP,
`ifdef PKT_SERIALIZER_EOP_EN
    ST_DATA,
    ST_EOP
`else
    ST_DATA
`endif
  } state_t;

endpackage

// File: rtl/sym_shifter.sv
// 9-bit symbol shifter: loads a symbol every 9th cycle and shifts it out LSB-first.
module sym_shifter
  import pkt_ser_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  sym_t sym_i,
  output logic sym_ena_o,
  output logic data_o
);

  logic [3:0] bit_cnt;
  sym_t       shifter;

  assign sym_ena_o = (bit_cnt == 4'd8);
  assign data_o    = shifter[0];

  // Bit counter wraps 0..8; the terminal count is the symbol boundary.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt <= '0;
    end else if (sym_ena_o) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Load the next symbol at the boundary, otherwise shift toward bit 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shifter <= COMMA;
    end else if (sym_ena_o) begin
      shifter <= sym_i;
    end else begin
      shifter <= {1'b0, shifter[SYM_W-1:1]};
    end
  end

endmodule

// File: rtl/pkt_serializer.sv
// Packet serializer: frames a NUM_BYTES payload with SOP commas onto a 1-bit
// 9b-symbol stream, idling on commas between packets.
// Build option: PKT_SERIALIZER_EOP_EN appends an EOP K-code after the payload.
module pkt_serializer
  import pkt_ser_pkg::*;
#(
  parameter int unsigned NUM_BYTES  = 4,
  parameter int unsigned SOP_COMMAS = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [NUM_BYTES*8-1:0] data_i,
  output logic                   data_o,
  output logic                   sym_ena_o,
  output logic                   busy_o,
  output logic                   eot_o
);

  localparam int unsigned      IDX_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [1:0]       LAST_SOP = 2'(SOP_COMMAS - 1);

  state_t                 state_q, state_d;
  logic [NUM_BYTES*8-1:0] payload_q;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [1:0]             sop_q, sop_d;
  logic                   eot_q, eot_d;
  logic                   accept;
  logic                   sym_ena;
  logic [7:0]             byte_sel;
  sym_t                   sym_sel;

  assign ready_o   = (state_q == ST_IDLE);
  assign busy_o    = ~ready_o;
  assign eot_o     = eot_q;
  assign sym_ena_o = sym_ena;
  assign accept    = valid_i & ready_o;

  // Symbol mux: what the shifter loads at the next boundary.
  always_comb begin
    byte_sel = '0;
    for (int unsigned b = 0; b < NUM_BYTES; b++) begin
      if (idx_q == IDX_W'(b)) byte_sel = payload_q[b*8 +: 8];
    end
    sym_sel = COMMA;
    case (state_q)
      ST_DATA: sym_sel = {1'b0, byte_sel};
`ifdef PKT_SERIALIZER_EOP_EN
      ST_EOP:  sym_sel = EOP;
`endif
      default: sym_sel = COMMA;
    endcase
  end

  // Next-state logic; state advances only on symbol boundaries once a packet is accepted.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sop_d   = sop_q;
    eot_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SOP;
          sop_d   = '0;
        end
      end
      ST_SOP: begin
        if (sym_ena) begin
          if (sop_q == LAST_SOP) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            sop_d = sop_q + 2'd1;
          end
        end
      end
      ST_DATA: begin
        if (sym_ena) begin
          if (idx_q == LAST_IDX) begin
`ifdef PKT_SERIALIZER_EOP_EN
            state_d = ST_EOP;
`else
            state_d = ST_IDLE;
            eot_d   = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef PKT_SERIALIZER_EOP_EN
      ST_EOP: begin
        if (sym_ena) begin
          state_d = ST_IDLE;
          eot_d   = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State, index, comma count and eot registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sop_q   <= '0;
      eot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sop_q   <= sop_d;
      eot_q   <= eot_d;
    end
  end

  // Payload is captured only on accept; data_i is ignored otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      payload_q <= '0;
    end else if (accept) begin
      payload_q <= data_i;
    end
  end

  sym_shifter u_shifter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .sym_i     (sym_sel),
    .sym_ena_o (sym_ena),
    .data_o    (data_o)
  );

endmodule

// File: tb/tb_pkt_serializer.sv
// Self-checking bench for pkt_serializer: queue-based reference model plus
// directed stream checks on a 4-byte/1-comma and a 1-byte/2-comma instance.
`timescale 1ns/1ps
module tb_pkt_serializer;

  localparam int NB    = 4;
  localparam int NB_B  = 1;
  localparam int SOP_B = 2;
  localparam logic [8:0] K_COMMA = 9'h13C;
  localparam logic [8:0] K_EOP   = 9'h1FD;
`ifdef PKT_SERIALIZER_EOP_EN
  localparam bit EOP_EN = 1'b1;
`else
  localparam bit EOP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0, valid_b = 1'b0;
  logic [NB*8-1:0]   data   = '0;
  logic [NB_B*8-1:0] data_b = '0;
  logic ready, dout, sena, busy, eot;
  logic ready_b, dout_b, sena_b, busy_b, eot_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pkt_serializer #(.NUM_BYTES(NB), .SOP_COMMAS(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready), .data_i(data),
    .data_o(dout), .sym_ena_o(sena), .busy_o(busy), .eot_o(eot)
  );

  pkt_serializer #(.NUM_BYTES(NB_B), .SOP_COMMAS(SOP_B)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_b), .ready_o(ready_b), .data_i(data_b),
    .data_o(dout_b), .sym_ena_o(sena_b), .busy_o(busy_b), .eot_o(eot_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (instance A) ----------------
  typedef struct packed { logic [8:0] sym; logic last; } ent_t;
  ent_t        q[$];
  int unsigned m_pos = 0;
  logic [8:0]  m_cur = K_COMMA;
  bit          m_eot = 1'b0;

  // A packet becomes a list of symbols: commas, payload bytes, optional EOP.
  function automatic void push_packet(input logic [NB*8-1:0] d);
    ent_t e;
    e.sym = K_COMMA; e.last = 1'b0; q.push_back(e);
    for (int i = 0; i < NB; i++) begin
      e.sym  = {1'b0, d[i*8 +: 8]};
      e.last = (i == NB-1) && !EOP_EN;
      q.push_back(e);
    end
    if (EOP_EN) begin
      e.sym = K_EOP; e.last = 1'b1; q.push_back(e);
    end
  endfunction

  always @(posedge clk or posedge rst) begin : m_step
    bit   acc, nx_eot;
    ent_t e;
    if (rst) begin
      m_pos = 0; m_cur = K_COMMA; q.delete(); m_eot = 1'b0;
    end else begin
      acc    = valid && (q.size() == 0);
      nx_eot = 1'b0;
      if (m_pos == 8) begin
        m_pos = 0;
        if (q.size() > 0) begin
          e = q.pop_front(); m_cur = e.sym; nx_eot = e.last;
        end else begin
          m_cur = K_COMMA;
        end
      end else begin
        m_pos++;
      end
      if (acc) push_packet(data);
      m_eot = nx_eot;
    end
  end

  // ---------------- per-cycle checks and symbol capture ----------------
  logic [8:0] rx_sh = '0, rx_sh_b = '0;
  logic [8:0] rx[$], rx_b[$], exp_q[$];
  int eot_cnt = 0, eot_cnt_b = 0;

  always @(negedge clk) begin
    chk("data_o",      32'(dout),    32'(m_cur[m_pos]));
    chk("sym_ena_o",   32'(sena),    32'(m_pos == 8));
    chk("b_sym_ena_o", 32'(sena_b),  32'(m_pos == 8));
    chk("ready_o",     32'(ready),   32'(q.size() == 0));
    chk("busy_o",      32'(busy),    32'(q.size() != 0));
    chk("eot_o",       32'(eot),     32'(m_eot));
    rx_sh   = {dout,   rx_sh[8:1]};
    rx_sh_b = {dout_b, rx_sh_b[8:1]};
    if (m_pos == 8) begin
      rx.push_back(rx_sh);
      rx_b.push_back(rx_sh_b);
    end
    if (eot)   eot_cnt++;
    if (eot_b) eot_cnt_b++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_rx();
    rx.delete(); rx_b.delete(); eot_cnt = 0; eot_cnt_b = 0;
  endtask

  task automatic wait_eot(input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!eot && n < budget);
    if (!eot) chk("eot_wait_timeout", 32'd0, 32'd1);
  endtask

  // Skip leading commas, then compare the captured stream to exp_q.
  task automatic cmp_stream(input string tag, input bit use_b, output int first);
    logic [8:0] s[$];
    int k = 0, nonc = 0, exp_nonc = 0;
    if (use_b) s = rx_b; else s = rx;
    while (k < s.size() && s[k] == K_COMMA) k++;
    first = k;
    foreach (exp_q[j])
      chk(tag, (k + j < s.size()) ? 32'(s[k+j]) : 32'hDEAD, 32'(exp_q[j]));
    foreach (s[j])     if (s[j] != K_COMMA)     nonc++;
    foreach (exp_q[j]) if (exp_q[j] != K_COMMA) exp_nonc++;
    chk({tag, "_count"}, 32'(nonc), 32'(exp_nonc));
  endtask

  initial begin
    int fa, fb, n;

    // Reset values
    step(); step();
    chk("rst_ready", 32'(ready),  32'd1);
    chk("rst_busy",  32'(busy),   32'd0);
    chk("rst_eot",   32'(eot),    32'd0);
    chk("rst_sena",  32'(sena),   32'd0);
    chk("rst_data",  32'(dout),   32'd0);
    chk("rst_b_ready", 32'(ready_b), 32'd1);
    chk("rst_b_busy",  32'(busy_b),  32'd0);
    rst = 1'b0;

    // Idle stream
    clear_rx();
    repeat (40) step();
    exp_q = '{};
    cmp_stream("idle", 1'b0, fa);
    chk("idle_syms_seen", 32'(rx.size() >= 3), 32'd1);

    // Single packet on both instances, accepted in the same cycle
    clear_rx();
    valid = 1'b1; data = 32'hDEADBEEF;
    valid_b = 1'b1; data_b = 8'hA5;
    step();
    valid = 1'b0; data = $urandom;
    valid_b = 1'b0; data_b = 8'(($urandom));
    wait_eot(200);
    repeat (60) step();
    exp_q = '{9'h0EF, 9'h0BE, 9'h0AD, 9'h0DE};
    if (EOP_EN) exp_q.push_back(K_EOP);
    exp_q.push_back(K_COMMA);
    cmp_stream("single", 1'b0, fa);
    chk("single_eot_cnt", 32'(eot_cnt), 32'd1);
    exp_q = '{9'h0A5};
    if (EOP_EN) exp_q.push_back(K_EOP);
    exp_q.push_back(K_COMMA);
    cmp_stream("b_single", 1'b1, fb);
    chk("b_sop_offset", 32'(fb - fa), 32'd1);
    chk("b_eot_cnt", 32'(eot_cnt_b), 32'd1);

    // Back-to-back with valid held high
    clear_rx();
    valid = 1'b1; data = 32'h11223344;
    step();
    data = 32'h55667788;
    wait_eot(200);
    step();
    valid = 1'b0;
    wait_eot(200);
    repeat (20) step();
    exp_q = '{9'h044, 9'h033, 9'h022, 9'h011};
    if (EOP_EN) exp_q.push_back(K_EOP);
    exp_q.push_back(K_COMMA);
    exp_q.push_back(9'h088); exp_q.push_back(9'h077);
    exp_q.push_back(9'h066); exp_q.push_back(9'h055);
    if (EOP_EN) exp_q.push_back(K_EOP);
    exp_q.push_back(K_COMMA);
    cmp_stream("b2b", 1'b0, fa);
    chk("b2b_eot_cnt", 32'(eot_cnt), 32'd2);

    // Busy guard: data/valid churn while busy must be ignored
    clear_rx();
    valid = 1'b1; data = 32'hCAFEF00D;
    step();
    for (int i = 0; i < 20; i++) begin
      data  = $urandom;
      valid = 1'($urandom_range(0, 1));
      step();
    end
    valid = 1'b0;
    wait_eot(200);
    repeat (20) step();
    exp_q = '{9'h00D, 9'h0F0, 9'h0FE, 9'h0CA};
    if (EOP_EN) exp_q.push_back(K_EOP);
    exp_q.push_back(K_COMMA);
    cmp_stream("busy_guard", 1'b0, fa);
    chk("busy_guard_eot_cnt", 32'(eot_cnt), 32'd1);

    // Reset while 0_BE is on the wire
    valid = 1'b1; data = 32'hDEADBEEF;
    step();
    valid = 1'b0;
    n = 0;
    while (m_cur != 9'h0BE && n < 100) begin step(); n++; end
    chk("reach_0BE", 32'(m_cur), 32'h0BE);
    repeat (3) step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    clear_rx();
    repeat (60) step();
    exp_q = '{};
    cmp_stream("abort", 1'b0, fa);
    chk("abort_eot_cnt", 32'(eot_cnt), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      valid = ($urandom_range(0, 9) < 3);
      data  = $urandom;
      step();
    end
    valid = 1'b0;
    repeat (120) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pkt_serializer.md
PKT_SERIALIZER -- requirements
Module: pkt_serializer

Interface
REQ-001 Parameter NUM_BYTES, default 4: payload bytes per packet, legal range 1..16.
REQ-002 Parameter SOP_COMMAS, default 1: K-code commas sent before each payload, legal range 1..4.
REQ-003 Port clk_i  in  1  sole clock; all logic is rising-edge.
REQ-004 Port rst_i  in  1  reset, asynchronous and active-high.
REQ-005 Port valid_i  in  1  packet request.
REQ-006 Port ready_o  out  1  block can accept a packet.
REQ-007 Port data_i  in  NUM_BYTES*8  payload; byte 0 is data_i[7:0].
REQ-008 Port data_o  out  1  serial symbol stream.
REQ-009 Port sym_ena_o  out  1  symbol-boundary strobe.
REQ-010 Port busy_o  out  1  packet in progress.
REQ-011 Port eot_o  out  1  end-of-packet pulse.

Function
REQ-012 Symbol is 9 bits {k, byte}; sent LSB-first: byte[0]..byte[7], then k.
REQ-013 A bit counter wraps 0..8; sym_ena_o SHALL be 1 while the count is 8, so it pulses every 9th cycle.
REQ-014 On each sym_ena_o cycle, the shifter SHALL load the symbol selected by the FSM; data_o = shifter bit 0.
REQ-015 With no packet active, the selected symbol SHALL be COMMA {1,8'h3C}, giving a continuous idle stream.
REQ-016 FSM states: ST_IDLE, ST_SOP, ST_DATA, ST_EOP (ST_EOP exists only with the macro in REQ-030).
REQ-017 ready_o = 1 only in ST_IDLE; a packet is accepted on a cycle with valid_i && ready_o.
REQ-018 On accept, data_i SHALL be captured into a payload register and the FSM SHALL go to ST_SOP; data_i is ignored at all other times.
REQ-019 ST_SOP: each boundary loads COMMA; after SOP_COMMAS loads, go to ST_DATA with index 0.
REQ-020 ST_DATA: each boundary loads {0, payload byte[index]} and increments the index.
REQ-021 After byte NUM_BYTES-1 loads, the FSM SHALL go to ST_EOP if the macro is defined, else ST_IDLE.
REQ-022 eot_o SHALL pulse high for exactly one cycle: the cycle after the boundary that loads the packet's last symbol.
REQ-023 The FSM SHALL re-enter ST_IDLE in that same cycle, so ready_o = 1 concurrently with eot_o.
REQ-024 valid_i asserted on the eot_o cycle SHALL be accepted; its first SOP comma loads at the next boundary, so back-to-back packets have no idle gap.
REQ-025 busy_o = 1 in every state except ST_IDLE.
REQ-026 The payload index width is clog2(NUM_BYTES), minimum 1 bit; the index SHALL NOT wrap inside a packet.

Reset
REQ-027 Reset SHALL force: state ST_IDLE, bit counter 0, shifter = COMMA, payload 0, index 0.
REQ-028 Output reset values: ready_o=1, busy_o=0, eot_o=0, sym_ena_o=0, data_o=0 (COMMA bit 0).
REQ-029 Reset mid-packet SHALL abandon the packet with no eot_o; the first sym_ena_o occurs on the 9th cycle after release.

Configuration
REQ-030 Macro PKT_SERIALIZER_EOP_EN: when defined, ST_EOP loads EOP {1,8'hFD} at one boundary, then the FSM goes to ST_IDLE and eot_o follows that load; when undefined, no EOP symbol and no ST_EOP logic.

Structure
REQ-031 Package pkt_ser_pkg SHALL hold: SYM_W=9, the symbol typedef, the COMMA and EOP constants, and the state enum.
REQ-032 Sub-module sym_shifter SHALL contain the 9-bit load/shift register, the bit counter and the sym_ena generation.
REQ-033 pkt_serializer SHALL contain the FSM, the payload register and the symbol mux.

Verification
REQ-034 Idle stream: reset, no valid -> data_o repeats 0,0,1,1,1,1,0,0,1; sym_ena_o every 9 cycles.
REQ-035 Single packet: NUM_BYTES=4, data 32'hDEADBEEF -> symbols 1_3C, 0_EF, 0_BE, 0_AD, 0_DE, then idle 1_3C; eot_o one cycle after 0_DE loads.
REQ-036 Back-to-back: valid_i held high with 32'h11223344 and 32'h55667788 -> 0_11 is followed directly by 1_3C, 0_88; two eot_o pulses.
REQ-037 Busy guard: change data_i and pulse valid_i while busy_o=1 -> transmitted bytes unchanged; no second packet.
REQ-038 Reset at 0_BE transmission -> next symbols are idle commas; no eot_o.
REQ-039 Macro and edge case: PKT_SERIALIZER_EOP_EN with NUM_BYTES=1, data 8'hA5 -> 1_3C, 0_A5, 1_FD; eot_o after 1_FD loads.
